// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit: opcodes, ALU codes, FSM states,
// flag-select encoding and the decoded-instruction record.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALTED
  } state_e;

  localparam logic [3:0] OP_ADDI = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_BR   = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // R-type opcodes pass straight through as the ALU function code.
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_NOT = 4'h5;
  localparam logic [3:0] ALU_SHL = 4'h6;
  localparam logic [3:0] ALU_SHR = 4'h7;
  localparam logic [3:0] ALU_SRA = 4'h8;
  localparam logic [3:0] ALU_MUL = 4'h9;
  localparam logic [3:0] ALU_SLT = 4'hA;
  localparam logic [3:0] ALU_MOV = 4'hB;

  // Index into the flag register {P,N,C,Z}.
  typedef enum logic [1:0] {
    FSEL_Z = 2'b00,
    FSEL_C = 2'b01,
    FSEL_N = 2'b10,
    FSEL_P = 2'b11
  } fsel_e;

  typedef enum logic [2:0] {
    IC_RTYPE,
    IC_ADDI,
    IC_JMP,
    IC_BR,
    IC_HLT
  } iclass_e;

  typedef struct packed {
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [3:0]  alu_op;
    logic [15:0] t;
    logic        sel_t;
    iclass_e     cls;
  } dec_t;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: maps the instruction register to
// register selects, ALU code, immediate and instruction class.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir_i,
  output dec_t        dec_o
);

  always_comb begin
    dec_o        = '0;
    dec_o.rd     = ir_i[11:8];
    dec_o.rs     = ir_i[7:4];
    dec_o.rt     = ir_i[3:0];
    dec_o.cls    = IC_RTYPE;
    case (ir_i[15:12])
      OP_ADDI: begin
        dec_o.alu_op = ALU_ADD;
        dec_o.t      = {{12{ir_i[3]}}, ir_i[3:0]};
        dec_o.sel_t  = 1'b1;
        dec_o.cls    = IC_ADDI;
      end
      OP_JMP:  dec_o.cls = IC_JMP;
      OP_BR:   dec_o.cls = IC_BR;
      OP_HLT:  dec_o.cls = IC_HLT;
      default: dec_o.alu_op = ir_i[15:12];
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetch / decode / execute / writeback / halted.
// Every output is a register; next values are computed from the next state.
module control_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        ifetch_req,
  input  logic        ifetch_ack,
  input  logic [15:0] instr,
  output logic [15:0] pc,
  input  logic        fZ,
  input  logic        fC,
  input  logic        fN,
  input  logic        fP,
  output logic        wen,
  output logic [3:0]  selRd,
  output logic [3:0]  selRs,
  output logic [3:0]  selRt,
  output logic [3:0]  aluOp,
  output logic [15:0] t,
  output logic        selT,
  output logic        halt
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d, ir_q, ir_d, t_q, t_d;
  logic [3:0]  flags_q, flags_d;
  logic [3:0]  rd_q, rd_d, rs_q, rs_d, rt_q, rt_d, alu_q, alu_d;
  logic        selt_q, selt_d, req_q, req_d, wen_q, wen_d, halt_q, halt_d;
  dec_t        dec;

  instr_decode u_dec (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    alu_d   = alu_q;
    t_d     = t_q;
    selt_d  = selt_q;
    case (state_q)
      S_FETCH: begin
        // Only an ack answering our own request counts as a fetch.
        if (req_q && ifetch_ack) begin
          ir_d    = instr;
          pc_d    = pc_q + 16'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        rd_d    = dec.rd;
        rs_d    = dec.rs;
        rt_d    = dec.rt;
        alu_d   = dec.alu_op;
        t_d     = dec.t;
        selt_d  = dec.sel_t;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (dec.cls)
          IC_JMP: begin
            pc_d    = {pc_q[15:12], ir_q[11:0]};
            state_d = S_FETCH;
          end
          IC_BR: begin
            // pc already points past the branch, so the offset is relative to BR+1.
            if (flags_q[ir_q[11:10]]) pc_d = pc_q + sext8(ir_q[7:0]);
            state_d = S_FETCH;
          end
          IC_HLT:  state_d = S_HALTED;
          default: state_d = S_WRITEBACK;
        endcase
      end
      S_WRITEBACK: begin
        flags_d = {fP, fN, fC, fZ};
        state_d = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
    req_d  = (state_d == S_FETCH);
    wen_d  = (state_d == S_WRITEBACK);
    halt_d = (state_d == S_HALTED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      alu_q   <= '0;
      t_q     <= '0;
      selt_q  <= 1'b0;
      req_q   <= 1'b0;
      wen_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      alu_q   <= alu_d;
      t_q     <= t_d;
      selt_q  <= selt_d;
      req_q   <= req_d;
      wen_q   <= wen_d;
      halt_q  <= halt_d;
    end
  end

  assign ifetch_req = req_q;
  assign pc         = pc_q;
  assign wen        = wen_q;
  assign selRd      = rd_q;
  assign selRs      = rs_q;
  assign selRt      = rt_q;
  assign aluOp      = alu_q;
  assign t          = t_q;
  assign selT       = selt_q;
  assign halt       = halt_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: the bench plays instruction memory,
// pushes expected decode/pc results per fetch and pops them as the DUT executes.
module tb_control_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0, rst = 1'b0;
  logic        ifetch_req, ifetch_ack = 1'b0;
  logic [15:0] instr = '0, pc;
  logic        fZ = 1'b0, fC = 1'b0, fN = 1'b0, fP = 1'b0;
  logic        wen, selT, halt;
  logic [3:0]  selRd, selRs, selRt, aluOp;
  logic [15:0] t;

  typedef struct {
    int          kind;  // 0 writeback, 1 jump/branch, 2 halt
    logic [3:0]  rd, rs, rt, alu;
    logic [15:0] imm;
    logic        selt;
    logic [15:0] npc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mpc = '0;
  logic [3:0]  mflags = '0;  // {P,N,C,Z}
  int          total = 0, bad = 0;

  control_unit dut (
    .clk(clk), .rst(rst), .ifetch_req(ifetch_req), .ifetch_ack(ifetch_ack),
    .instr(instr), .pc(pc), .fZ(fZ), .fC(fC), .fN(fN), .fP(fP), .wen(wen),
    .selRd(selRd), .selRs(selRs), .selRt(selRt), .aluOp(aluOp), .t(t),
    .selT(selT), .halt(halt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"}, ifetch_req, 1'b0);
    chk({tag, "_pc"}, pc, 16'h0000);
    chk({tag, "_wen"}, wen, 1'b0);
    chk({tag, "_sel"}, {selRd, selRs, selRt, aluOp}, 16'h0000);
    chk({tag, "_t"}, t, 16'h0000);
    chk({tag, "_selT"}, selT, 1'b0);
    chk({tag, "_halt"}, halt, 1'b0);
  endtask

  // One instruction: wait for request, delay ack, fetch, then follow it to completion.
  task automatic issue(input logic [15:0] ins, input logic [3:0] flg, input int dly, input bit abort_wb);
    exp_t        e, g;
    logic [3:0]  op;
    logic [15:0] nxt;
    int          n;
    n = 0;
    while (ifetch_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_wait", ifetch_req, 1'b1);
    chk("pc_fetch", pc, mpc);
    {fP, fN, fC, fZ} = flg;
    repeat (dly) begin
      chk("hold_req", ifetch_req, 1'b1);
      chk("hold_pc", pc, mpc);
      chk("hold_wen", wen, 1'b0);
      @(negedge clk);
    end
    op    = ins[15:12];
    nxt   = mpc + 16'd1;
    e.kind = 0; e.rd = ins[11:8]; e.rs = ins[7:4]; e.rt = ins[3:0];
    e.alu = 4'h0; e.imm = 16'h0000; e.selt = 1'b0; e.npc = nxt;
    if (op < 4'hC) e.alu = op;
    else if (op == 4'hC) begin
      e.alu = ALU_ADD; e.imm = {{12{ins[3]}}, ins[3:0]}; e.selt = 1'b1;
    end else if (op == 4'hD) begin
      e.kind = 1; e.npc = {nxt[15:12], ins[11:0]};
    end else if (op == 4'hE) begin
      e.kind = 1;
      if (mflags[ins[11:10]]) e.npc = nxt + {{8{ins[7]}}, ins[7:0]};
    end else e.kind = 2;
    ifetch_ack = 1'b1;
    instr      = ins;
    sb.push_back(e);
    @(negedge clk);
    ifetch_ack = 1'b0;
    chk("dec_req_low", ifetch_req, 1'b0);
    chk("dec_pc_inc", pc, nxt);
    @(negedge clk);
    g = sb.pop_front();
    chk("ex_sel", {selRd, selRs, selRt}, {4'h0, g.rd, g.rs, g.rt});
    chk("ex_wen", wen, 1'b0);
    if (g.kind == 0) begin
      chk("ex_alu", aluOp, g.alu);
      chk("ex_t", t, g.imm);
      chk("ex_selT", selT, g.selt);
    end
    @(negedge clk);
    if (g.kind == 0) begin
      chk("wb_wen", wen, 1'b1);
      chk("wb_req", ifetch_req, 1'b0);
      if (abort_wb) begin
        rst = 1'b0;
        #1;
        chk_reset_outs("abort");
        @(negedge clk);
        chk_reset_outs("abort_hold");
        rst = 1'b1;
        @(negedge clk);
        chk("abort_req_first", ifetch_req, 1'b1);
        chk("abort_wen", wen, 1'b0);
        mpc = 16'h0000; mflags = 4'h0;
      end else begin
        mflags = flg;
        @(negedge clk);
        chk("wb_pulse_end", wen, 1'b0);
        chk("wb_next_req", ifetch_req, 1'b1);
        chk("wb_next_pc", pc, g.npc);
        mpc = g.npc;
      end
    end else if (g.kind == 1) begin
      chk("jb_req", ifetch_req, 1'b1);
      chk("jb_pc", pc, g.npc);
      chk("jb_wen", wen, 1'b0);
      mpc = g.npc;
    end else begin
      ifetch_ack = 1'b1;
      repeat (8) begin
        chk("hlt_halt", halt, 1'b1);
        chk("hlt_req", ifetch_req, 1'b0);
        chk("hlt_wen", wen, 1'b0);
        @(negedge clk);
      end
      ifetch_ack = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b1;
    #1;
    chk("rel_req_low", ifetch_req, 1'b0);
    @(negedge clk);
    chk("rel_req_first", ifetch_req, 1'b1);

    issue(16'h0123, 4'b0001, 0, 1'b0);  // ALU, latches Z
    issue(16'hC21F, 4'b0001, 0, 1'b0);  // ADDI imm -1
    issue(16'h1456, 4'b0001, 5, 1'b0);  // delayed ack
    issue(16'hD010, 4'b0000, 0, 1'b0);  // JMP to 0x0010
    issue(16'hE0FE, 4'b0000, 0, 1'b0);  // BR Z taken -> 0x000F
    issue(16'h2000, 4'b0010, 0, 1'b0);  // latch C only
    issue(16'hE0FE, 4'b0000, 0, 1'b0);  // BR Z not taken -> 0x0011
    issue(16'hE4FE, 4'b0000, 0, 1'b0);  // BR C taken -> 0x0010
    issue(16'hD000, 4'b0000, 0, 1'b0);  // JMP 0x0000
    issue(16'h3000, 4'b0001, 0, 1'b0);  // latch Z
    issue(16'hD000, 4'b0000, 0, 1'b0);  // JMP 0x0000
    issue(16'hE0FE, 4'b0000, 0, 1'b0);  // BR back to 0xFFFF
    issue(16'h4111, 4'b0000, 0, 1'b0);  // fetch at 0xFFFF wraps pc
    issue(16'hF000, 4'b0000, 0, 1'b0);  // HLT

    rst = 1'b0;
    #1;
    chk_reset_outs("halt_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mpc = 16'h0000; mflags = 4'h0;
    issue(16'h5777, 4'b0001, 0, 1'b1);  // reset during writeback, Z must not latch
    issue(16'hE0FE, 4'b0000, 0, 1'b0);  // flags cleared -> not taken, pc 0x0001

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
